mdu_sequencer: RTL and testbench

- Iterative multiply/divide unit controller for the 5-stage MIPS pipeline; owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo from the EX stage and sequences a shared 32-iteration shift-add / restoring-divide datapath.
- Raises a pipeline stall when an MDU op or an mfhi/mflo read meets a busy unit.
- Sits beside the ALU and its function decoder; it does not use the ALU.

---
 rtl/mdu_sequencer_if.sv | 26 ++
 rtl/mdu_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer bus: MDU op request, mf read request, flush, and HI/LO results.
interface mdu_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mf_req;
    logic             flush;
    logic             busy;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div0;

    modport master (
        output op_valid, op, a, b, mf_req, flush,
        input  busy, stall, hi, lo, div0
    );

    modport slave (
        input  op_valid, op, a, b, mf_req, flush,
        output busy, stall, hi, lo, div0
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative MIPS multiply/divide sequencer owning HI/LO (shift-add multiply, restoring divide).
// Optional MDU_DIV0_FAST_EN: divide-by-zero short-cuts straight to FIX and raises a sticky div0 flag.
module mdu_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic           clk,
    input  logic           reset,
    mdu_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(ITER);
    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic             sgn_q, sgn_d, isdiv_q, isdiv_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d;
`ifdef MDU_DIV0_FAST_EN
    logic             dz_q, dz_d;
    logic             div0_q, div0_d;
`endif

    logic             accept;
    logic             start;
    logic             op_signed;
    logic             op_div;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_rem_sh, div_diff;
    logic             div_ok;
    logic [ACC_W-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Operand decode and one iteration of each datapath
    always_comb begin
        accept     = bus.op_valid & ~bus.flush & (state_q == S_IDLE);
        op_signed  = (bus.op == OP_MULT) | (bus.op == OP_DIV);
        op_div     = (bus.op == OP_DIV)  | (bus.op == OP_DIVU);
        start      = accept & (op_signed | op_div | (bus.op == OP_MULTU));
        abs_a      = (op_signed & bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b      = (op_signed & bus.b[WIDTH-1]) ? -bus.b : bus.b;
        mul_sum    = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_rem_sh = acc_q[ACC_W-1:WIDTH-1];
        div_diff   = div_rem_sh - {1'b0, opnd_q};
        div_ok     = ~div_diff[WIDTH];
        prod_fix   = (sgn_q & (sa_q ^ sb_q)) ? -acc_q : acc_q;
        quo_fix    = (sgn_q & (sa_q ^ sb_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix    = (sgn_q & sa_q) ? -acc_q[ACC_W-1:WIDTH] : acc_q[ACC_W-1:WIDTH];
    end

    // Next-state and register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sgn_d   = sgn_q;
        isdiv_d = isdiv_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MDU_DIV0_FAST_EN
        dz_d    = dz_q;
        div0_d  = div0_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept && bus.op == OP_MTHI) hi_d = bus.a;
                if (accept && bus.op == OP_MTLO) lo_d = bus.a;
                if (start) begin
                    sgn_d   = op_signed;
                    sa_d    = op_signed & bus.a[WIDTH-1];
                    sb_d    = op_signed & bus.b[WIDTH-1];
                    isdiv_d = op_div;
                    cnt_d   = '0;
                    opnd_d  = op_div ? abs_b : abs_a;
                    acc_d   = {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
                    state_d = op_div ? S_DIV : S_MUL;
`ifdef MDU_DIV0_FAST_EN
                    // Preload what 32 restoring steps against zero would leave behind
                    dz_d = op_div & (bus.b == '0);
                    if (dz_d) begin
                        acc_d   = {abs_a, {WIDTH{1'b1}}};
                        state_d = S_FIX;
                    end
`endif
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = {(div_ok ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], div_ok};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                if (isdiv_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
`ifdef MDU_DIV0_FAST_EN
                if (dz_q) div0_d = 1'b1;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A squash abandons the op without touching architectural state
        if (bus.flush && state_q != S_IDLE) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
`ifdef MDU_DIV0_FAST_EN
            div0_d  = div0_q;
`endif
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            sgn_q   <= 1'b0;
            isdiv_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
`ifdef MDU_DIV0_FAST_EN
            dz_q    <= 1'b0;
            div0_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sgn_q   <= sgn_d;
            isdiv_q <= isdiv_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
`ifdef MDU_DIV0_FAST_EN
            dz_q    <= dz_d;
            div0_q  <= div0_d;
`endif
        end
    end

    assign bus.busy  = busy_q;
    assign bus.stall = busy_q & (bus.op_valid | bus.mf_req);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
`ifdef MDU_DIV0_FAST_EN
    assign bus.div0  = div0_q;
`else
    assign bus.div0  = 1'b0;
`endif
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed plan vectors plus random ops against an arithmetic reference.
module tb_mdu_sequencer;
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;
    logic div0_exp = 1'b0;

    mdu_sequencer_if #(.WIDTH(32)) bus ();
    mdu_sequencer #(.WIDTH(32), .ITER(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: {hi,lo} computed directly from MIPS arithmetic rules
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            OP_MULT:  r = 64'(sx * sy);
            OP_MULTU: r = {32'd0, x} * {32'd0, y};
            OP_DIV:   if (y == 32'd0) r = {x, (x[31] ? 32'd1 : 32'hFFFF_FFFF)};
                      else            r = {32'(sx % sy), 32'(sx / sy)};
            OP_DIVU:  if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                      else            r = {x % y, x / y};
            default:  r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic int exp_busy(input logic [2:0] o, input logic [31:0] y);
`ifdef MDU_DIV0_FAST_EN
        if ((o == OP_DIV || o == OP_DIVU) && y == 32'd0) return 1;
`endif
        return 33;
    endfunction

    function automatic logic exp_div0_after(input logic prev, input logic [2:0] o, input logic [31:0] y);
`ifdef MDU_DIV0_FAST_EN
        if ((o == OP_DIV || o == OP_DIVU) && y == 32'd0) return 1'b1;
`endif
        return prev & (o == o) & (y == y);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.op_valid = 1'b0;
        bus.op       = OP_NONE;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        bus.mf_req   = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
        step();
        bus.op_valid = 1'b0;
        bus.op       = OP_NONE;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        bus.op_valid = 1'b1;
        bus.mf_req   = 1'b1;
        step();
        step();
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        nvec++; if (bus.stall !== 1'b0) begin nerr++; $display("FAIL reset stall: got %b want 0", bus.stall); end
        nvec++; if (bus.hi !== 32'd0) begin nerr++; $display("FAIL reset hi: got %h want 0", bus.hi); end
        nvec++; if (bus.lo !== 32'd0) begin nerr++; $display("FAIL reset lo: got %h want 0", bus.lo); end
        nvec++; if (bus.div0 !== 1'b0) begin nerr++; $display("FAIL reset div0: got %b want 0", bus.div0); end
        idle_inputs();
        reset = 1'b0;
        step();
    endtask

    task automatic test_mtx();
        logic [31:0] x, y;
        for (int i = 0; i < 4; i++) begin
            x = $urandom;
            y = $urandom;
            issue(OP_MTHI, x, 32'd0);
            issue(OP_MTLO, y, 32'd0);
            bus.mf_req = 1'b1;
            nvec++; if (bus.hi !== x) begin nerr++; $display("FAIL mthi%0d: got %h want %h", i, bus.hi, x); end
            nvec++; if (bus.lo !== y) begin nerr++; $display("FAIL mtlo%0d: got %h want %h", i, bus.lo, y); end
            nvec++; if (bus.stall !== 1'b0) begin nerr++; $display("FAIL mtx%0d stall: got %b want 0", i, bus.stall); end
            bus.mf_req = 1'b0;
        end
    endtask

    task automatic test_plan();
        logic [2:0]  ops [9];
        logic [31:0] va [9];
        logic [31:0] vb [9];
        logic [63:0] e;
        int n;
        ops = '{OP_MULTU, OP_MULT, OP_DIV, OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_MULT, OP_MULTU};
        va  = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100,
                32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        vb  = '{32'd2, 32'd3, 32'd2, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 9; i++) begin
            e = ref_result(ops[i], va[i], vb[i]);
            div0_exp = exp_div0_after(div0_exp, ops[i], vb[i]);
            issue(ops[i], va[i], vb[i]);
            wait_idle(n);
            nvec++; if (n !== exp_busy(ops[i], vb[i])) begin nerr++; $display("FAIL plan%0d busy cycles: got %0d want %0d", i, n, exp_busy(ops[i], vb[i])); end
            nvec++; if (bus.hi !== e[63:32]) begin nerr++; $display("FAIL plan%0d hi: got %h want %h", i, bus.hi, e[63:32]); end
            nvec++; if (bus.lo !== e[31:0]) begin nerr++; $display("FAIL plan%0d lo: got %h want %h", i, bus.lo, e[31:0]); end
            nvec++; if (bus.div0 !== div0_exp) begin nerr++; $display("FAIL plan%0d div0: got %b want %b", i, bus.div0, div0_exp); end
        end
    endtask

    task automatic test_stall();
        bus.mf_req = 1'b1;
        issue(OP_DIVU, 32'd100, 32'd7);
        for (int c = 1; c <= 33; c++) begin
            nvec++; if (bus.stall !== 1'b1) begin nerr++; $display("FAIL stall cycle N+%0d: got %b want 1", c, bus.stall); end
            step();
        end
        nvec++; if (bus.stall !== 1'b0) begin nerr++; $display("FAIL stall N+34: got %b want 0", bus.stall); end
        nvec++; if (bus.lo !== 32'd14) begin nerr++; $display("FAIL stall divu lo: got %h want %h", bus.lo, 32'd14); end
        nvec++; if (bus.hi !== 32'd2) begin nerr++; $display("FAIL stall divu hi: got %h want %h", bus.hi, 32'd2); end
        bus.mf_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        logic [63:0] e1, e2;
        int n;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        e1 = ref_result(OP_MULT, a1, b1);
        e2 = ref_result(OP_MULTU, a2, b2);
        issue(OP_MULT, a1, b1);
        // Pipeline holds the next MDU instruction while the unit is busy
        bus.op_valid = 1'b1; bus.op = OP_MULTU; bus.a = a2; bus.b = b2;
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            nvec++; if (bus.stall !== 1'b1) begin nerr++; $display("FAIL b2b held stall %0d: got %b want 1", n, bus.stall); end
            n++;
            step();
        end
        nvec++; if (n !== 33) begin nerr++; $display("FAIL b2b first busy: got %0d want 33", n); end
        nvec++; if (bus.stall !== 1'b0) begin nerr++; $display("FAIL b2b idle stall: got %b want 0", bus.stall); end
        nvec++; if ({bus.hi, bus.lo} !== e1) begin nerr++; $display("FAIL b2b first result: got %h want %h", {bus.hi, bus.lo}, e1); end
        step();
        bus.op_valid = 1'b0; bus.op = OP_NONE;
        wait_idle(n);
        nvec++; if (n !== 33) begin nerr++; $display("FAIL b2b second busy: got %0d want 33", n); end
        nvec++; if ({bus.hi, bus.lo} !== e2) begin nerr++; $display("FAIL b2b second result: got %h want %h", {bus.hi, bus.lo}, e2); end
    endtask

    task automatic test_flush();
        issue(OP_MTHI, 32'hA5A5_A5A5, 32'd0);
        issue(OP_MTLO, 32'hA5A5_A5A5, 32'd0);
        issue(OP_MULT, $urandom, $urandom);
        for (int i = 0; i < 10; i++) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL flush mul busy: got %b want 0", bus.busy); end
        nvec++; if (bus.hi !== 32'hA5A5_A5A5) begin nerr++; $display("FAIL flush mul hi: got %h want a5a5a5a5", bus.hi); end
        nvec++; if (bus.lo !== 32'hA5A5_A5A5) begin nerr++; $display("FAIL flush mul lo: got %h want a5a5a5a5", bus.lo); end
        issue(OP_MTHI, 32'h0000_1234, 32'd0);
        nvec++; if (bus.hi !== 32'h0000_1234) begin nerr++; $display("FAIL flush then mthi: got %h want 00001234", bus.hi); end
        // Squash landing on the final (FIX) cycle of a divide
        issue(OP_DIVU, 32'd1000, 32'd3);
        for (int i = 0; i < 32; i++) step();
        nvec++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL flush fix busy: got %b want 1", bus.busy); end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        nvec++; if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 32'h0000_1234, 32'hA5A5_A5A5}) begin
            nerr++; $display("FAIL flush fix state: got %b %h %h want 0 00001234 a5a5a5a5", bus.busy, bus.hi, bus.lo); end
        // Flush in IDLE drops the presented op
        bus.flush = 1'b1;
        issue(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
        nvec++; if (bus.lo !== 32'hA5A5_A5A5) begin nerr++; $display("FAIL flush idle mtlo: got %h want a5a5a5a5", bus.lo); end
        issue(OP_MULT, 32'd3, 32'd5);
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL flush idle mult busy: got %b want 0", bus.busy); end
        bus.flush = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        logic [63:0] e;
        int n;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(1, 4));
            case ($urandom_range(0, 7))
                0: x = 32'h8000_0000;
                1: x = 32'hFFFF_FFFF;
                2: x = 32'h7FFF_FFFF;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: y = 32'd1;
                3: y = 32'($urandom_range(1, 300));
                default: y = $urandom;
            endcase
            e = ref_result(o, x, y);
            div0_exp = exp_div0_after(div0_exp, o, y);
            issue(o, x, y);
            wait_idle(n);
            nvec++; if (n !== exp_busy(o, y)) begin nerr++; $display("FAIL rnd%0d op%0d busy cycles: got %0d want %0d", i, o, n, exp_busy(o, y)); end
            nvec++; if ({bus.hi, bus.lo} !== e) begin nerr++; $display("FAIL rnd%0d op%0d a=%h b=%h hi:lo: got %h want %h", i, o, x, y, {bus.hi, bus.lo}, e); end
            nvec++; if (bus.div0 !== div0_exp) begin nerr++; $display("FAIL rnd%0d div0: got %b want %b", i, bus.div0, div0_exp); end
        end
    endtask

    task automatic test_async_reset();
        issue(OP_MTHI, 32'h1111_2222, 32'd0);
        issue(OP_MTLO, 32'h3333_4444, 32'd0);
        issue(OP_DIV, $urandom, 32'd3);
        for (int i = 0; i < 5; i++) step();
        #2;
        reset = 1'b1;
        div0_exp = 1'b0;
        #1;
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL async reset busy: got %b want 0", bus.busy); end
        nvec++; if (bus.hi !== 32'd0) begin nerr++; $display("FAIL async reset hi: got %h want 0", bus.hi); end
        nvec++; if (bus.lo !== 32'd0) begin nerr++; $display("FAIL async reset lo: got %h want 0", bus.lo); end
        nvec++; if (bus.div0 !== div0_exp) begin nerr++; $display("FAIL async reset div0: got %b want 0", bus.div0); end
        step();
        reset = 1'b0;
        step();
        issue(OP_MTLO, 32'd5, 32'd0);
        nvec++; if (bus.lo !== 32'd5) begin nerr++; $display("FAIL post-reset mtlo: got %h want 5", bus.lo); end
        nvec++; if (bus.hi !== 32'd0) begin nerr++; $display("FAIL post-reset hi: got %h want 0", bus.hi); end
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL post-reset busy: got %b want 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_mtx();
        test_plan();
        test_stall();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
